// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: holds the PC, fetches one word at a time over
// a req/gnt/rvalid memory handshake and presents the registered instruction,
// its PC and decoded fields to the core with a valid/ready handshake.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en_in,
    output logic               imem_req_out,
    output logic [ADDR_W-1:0]  imem_addr_out,
    input  logic               imem_gnt_in,
    input  logic               imem_rvalid_in,
    input  logic [INSTR_W-1:0] imem_rdata_in,
    output logic               instr_valid_out,
    input  logic               instr_ready_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [6:0]         op_code_out,
    output logic [2:0]         func3_out,
    output logic [6:0]         func7_out,
    input  logic               redirect_in,
    input  logic [ADDR_W-1:0]  redirect_addr_in
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Sequential step and word-alignment mask for redirect targets.
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(3'd4);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(2'b11));

    state_t               state_r;
    state_t               state_s;
    logic [ADDR_W-1:0]    pc_r;
    logic [ADDR_W-1:0]    pc_s;
    logic                 req_r;
    logic                 valid_r;
    logic [INSTR_W-1:0]   instr_r;
    logic [ADDR_W-1:0]    pc_out_r;
    logic                 accept_s;
    logic                 load_s;

    // Next-state, next-PC and response-capture decode.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        accept_s = valid_r & instr_ready_in;
        load_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fetch_en_in) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // A raised request is held until granted, whatever fetch_en does.
                if (imem_gnt_in) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_in) begin
                    load_s  = 1'b1;
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (accept_s) begin
                    if (redirect_in) begin
                        pc_s = redirect_addr_in & WORD_MASK;
                    end else begin
                        pc_s = pc_r + PC_STEP;
                    end
                    if (fetch_en_in) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, PC and registered handshake outputs derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            pc_r    <= RESET_PC;
            req_r   <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            req_r   <= (state_s == ST_REQ);
            valid_r <= (state_s == ST_HOLD);
        end
    end

    // Capture the returned instruction and the PC it was fetched from.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_r  <= {INSTR_W{1'b0}};
            pc_out_r <= RESET_PC;
        end else if (load_s) begin
            instr_r  <= imem_rdata_in;
            pc_out_r <= pc_r;
        end else begin
            instr_r  <= instr_r;
            pc_out_r <= pc_out_r;
        end
    end

    // The PC only changes on accept (in HOLD), so it is stable while requesting.
    assign imem_req_out    = req_r;
    assign imem_addr_out   = pc_r;
    assign instr_valid_out = valid_r;
    assign instr_out       = instr_r;
    assign pc_out          = pc_out_r;
    assign op_code_out     = instr_r[6:0];
    assign func3_out       = instr_r[14:12];
    assign func7_out       = instr_r[31:25];

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch front end for the FRiscV core; it produces the instruction stream that the main controller decodes.
- Holds the PC, issues word requests to instruction memory over a req/gnt/rvalid handshake and registers the returned instruction.
- Presents the instruction, its PC and the extracted op_code/func3/func7 fields to the datapath with a valid/ready handshake.
- Takes the next-PC decision (sequential or redirect) from the controller/datapath when an instruction is accepted.

Parameters:
ADDR_W, 32, width of PC and instruction-memory address
INSTR_W, 32, instruction width (fixed RV32, must be 32)
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-high reset
fetch_en_in  input  1  enable fetching; low parks the unit after any in-flight fetch completes
imem_req_out  output  1  instruction memory request
imem_addr_out  output  ADDR_W  request address (word aligned)
imem_gnt_in  input  1  memory accepts request this cycle
imem_rvalid_in  input  1  read data valid
imem_rdata_in  input  INSTR_W  read data
instr_valid_out  output  1  instruction registers hold a valid instruction
instr_ready_in  input  1  core consumes the instruction this cycle
instr_out  output  INSTR_W  registered instruction
pc_out  output  ADDR_W  PC of instr_out
op_code_out  output  7  instr_out[6:0]
func3_out  output  3  instr_out[14:12]
func7_out  output  7  instr_out[31:25]
redirect_in  input  1  on accept: next PC = redirect_addr_in (taken branch/jump)
redirect_addr_in  input  ADDR_W  redirect target

Behaviour:
- Reset values (async, immediate): state=IDLE, pc=RESET_PC, imem_req_out=0, imem_addr_out=RESET_PC, instr_valid_out=0, instr_out=0 (so op_code/func3/func7=0), pc_out=RESET_PC.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: req=0. If fetch_en_in=1, go to REQ next cycle.
- REQ:
  - imem_req_out=1, imem_addr_out=pc; both held stable until imem_gnt_in.
  - On gnt, go to WAIT.
  - fetch_en_in is not sampled in REQ; a raised request is never withdrawn.
- WAIT:
  - req=0. rvalid never arrives in the gnt cycle (protocol: at least 1 cycle after gnt).
  - On imem_rvalid_in: instr_out<=imem_rdata_in, pc_out<=pc, go to HOLD.
- HOLD:
  - instr_valid_out=1; instr_out, pc_out and the field outputs are stable until accepted.
  - Accept is instr_valid_out & instr_ready_in.
  - On accept, pc<=redirect_in ? {redirect_addr_in[ADDR_W-1:2],2'b00} : pc+4, and instr_valid_out drops the next cycle.
  - After accept, go to REQ if fetch_en_in=1, else IDLE.
- redirect_in and redirect_addr_in are sampled only in the accept cycle and ignored otherwise.
- Field outputs are pure slices of the registered instr_out; no combinational path from imem_rdata_in.
- Arithmetic: pc+4 is modulo 2^ADDR_W; PC 0xFFFF_FFFC wraps to 0x0000_0000 with no flag.
- Redirect target bits [1:0] are forced to 0.
- Minimum latency with gnt same cycle and rvalid one cycle later:
  - REQ cycle N, rvalid N+1, instr_valid_out N+2.
  - If accepted at N+2, next req at N+3, giving 3 cycles per instruction.
- Backpressure: instr_ready_in low holds HOLD indefinitely; no new request is issued while HOLD.
- fetch_en_in low mid-operation: the outstanding REQ/WAIT completes and the instruction is delivered to HOLD; after accept the unit goes to IDLE with pc already advanced.
- rvalid received in IDLE/REQ/HOLD (stale after reset) is ignored.
- Reset mid-operation: async return to reset values; any memory response in flight is discarded per the rule above.

Test Plan:
- Sequential fetch: reset, fetch_en=1, gnt immediate, rvalid 1 cycle later, ready=1 -> addresses 0x0, 0x4, 0x8 in successive requests 3 cycles apart; instr_out/pc_out match; instr 0x00208033 gives op_code=0x33, func3=0, func7=0.
- Backpressure: ready=0 for 5 cycles in HOLD -> instr_valid_out, instr_out and pc_out stable; imem_req_out=0 throughout; on ready=1, next request issued the following cycle.
- Redirect: accept instr at pc=0x8 with redirect_in=1, redirect_addr=0x103 -> next imem_addr_out=0x100; redirect pulsed outside accept -> ignored, next address 0xC.
- Slow memory: gnt delayed 3 cycles, rvalid 4 cycles after gnt -> req/addr stable until gnt; instr_valid_out exactly 1 cycle after rvalid.
- Disable mid-fetch: drop fetch_en in WAIT -> instruction still delivered; after accept, state IDLE, pc=prev+4, no request; re-enable -> request at that pc.
- Wrap and reset: RESET_PC=0xFFFF_FFFC -> second fetch at 0x0; assert rst in WAIT then deliver rvalid after release -> response ignored, outputs at reset values, first new request to RESET_PC.
